ofdm_rx_80216: RTL and testbench

OFDM_RX_80216 -- requirements
Module: ofdm_rx_80216

---
 rtl/ofdm_rx_80216_if.sv | 25 ++
 rtl/ofdm_rx_80216.sv | 168 ++++++++++++++++
 tb/tb_ofdm_rx_80216.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ofdm_rx_80216_if.sv
// Sample-in / soft-byte-out bus of the 802.16 OFDM receiver front end.
// The master drives samples and the downstream ack; the slave is the receiver.
interface ofdm_rx_80216_if;
    logic [15:0] i_ch_i;
    logic [15:0] q_ch_i;
    logic        cyc_i;
    logic        stb_i;
    logic        ack_o;
    logic [3:0]  snr;
    logic [7:0]  dat_o;
    logic        we_o;
    logic        stb_o;
    logic        cyc_o;
    logic        ack_i;

    modport master (
        output i_ch_i, q_ch_i, cyc_i, stb_i, snr, ack_i,
        input  ack_o, dat_o, we_o, stb_o, cyc_o
    );

    modport slave (
        input  i_ch_i, q_ch_i, cyc_i, stb_i, snr, ack_i,
        output ack_o, dat_o, we_o, stb_o, cyc_o
    );
endinterface

// File: rtl/ofdm_rx_80216.sv
// OFDM receiver front end: strips the cyclic prefix of each symbol and turns every
// remaining I/Q sample into two SNR-scaled, saturated signed soft-bit bytes.
module ofdm_rx_80216 #(
    parameter int SYM_LEN = 288,
    parameter int CP_LEN  = 32
) (
    input  logic               clk,
    input  logic               rst,
    ofdm_rx_80216_if.slave     bus
);
    localparam int POS_W = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(SYM_LEN - 1);
    localparam logic [POS_W-1:0] CP_END   = POS_W'(CP_LEN);

    typedef enum logic [1:0] {
        HOLD_EMPTY = 2'd0,
        HOLD_I     = 2'd1,
        HOLD_Q     = 2'd2
    } hold_state_t;

    // Arithmetic right shift followed by a symmetric clamp to [-127, +127].
    function automatic logic [7:0] soft_byte(input logic [15:0] sample, input logic [3:0] shamt);
        logic signed [15:0] shifted;
        shifted = $signed(sample) >>> shamt;
        if (shifted > 16'sd127) begin
            soft_byte = 8'h7f;
        end else if (shifted < -16'sd127) begin
            soft_byte = 8'h81;
        end else begin
            soft_byte = shifted[7:0];
        end
    endfunction

    // Higher SNR codes keep more of the sample's magnitude; codes above 8 saturate at no shift.
    function automatic logic [3:0] shift_of(input logic [3:0] code);
        if (code >= 4'd8) begin
            shift_of = 4'd0;
        end else begin
            shift_of = 4'd8 - code;
        end
    endfunction

    hold_state_t      state_q;
    logic [7:0]       dat_q;
    logic [7:0]       q_byte_q;
    logic             stb_q;

    logic [POS_W-1:0] pos_q,   pos_d;
    logic [3:0]       snr_q,   snr_d;
    logic             cyc_o_q, cyc_o_d;
    logic             drain_q, drain_d;

    logic             in_cp_s;
    logic             ack_s;
    logic             load_s;
    logic             first_s;
    logic [3:0]       shamt_s;

    assign in_cp_s = (pos_q < CP_END);
    assign ack_s   = ~rst & bus.cyc_i & bus.stb_i & ~drain_q
                   & (in_cp_s | (state_q == HOLD_EMPTY));
    assign load_s  = ack_s & ~in_cp_s;
    // cyc_o is still low on the first accepted sample of a frame.
    assign first_s = ack_s & ~cyc_o_q;
    assign shamt_s = shift_of(first_s ? bus.snr : snr_q);

    // Next-state logic for symbol position, latched SNR and frame/drain tracking.
    always_comb begin
        pos_d   = pos_q;
        snr_d   = snr_q;
        cyc_o_d = cyc_o_q;
        drain_d = drain_q;

        if (!bus.cyc_i) begin
            pos_d = '0;
        end else if (ack_s) begin
            pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
        end else begin
            pos_d = pos_q;
        end

        if (first_s) begin
            snr_d = bus.snr;
        end else begin
            snr_d = snr_q;
        end

        // Drain completion wins over everything else so a waiting frame starts clean.
        if (drain_q && (state_q == HOLD_EMPTY)) begin
            cyc_o_d = 1'b0;
            drain_d = 1'b0;
        end else if (cyc_o_q && !bus.cyc_i) begin
            cyc_o_d = 1'b1;
            drain_d = 1'b1;
        end else if (first_s) begin
            cyc_o_d = 1'b1;
            drain_d = drain_q;
        end else begin
            cyc_o_d = cyc_o_q;
            drain_d = drain_q;
        end
    end

    // Frame-control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q   <= '0;
            snr_q   <= 4'd0;
            cyc_o_q <= 1'b0;
            drain_q <= 1'b0;
        end else begin
            pos_q   <= pos_d;
            snr_q   <= snr_d;
            cyc_o_q <= cyc_o_d;
            drain_q <= drain_d;
        end
    end

    // One-sample hold: presents the I byte, then the Q byte, then frees the slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= HOLD_EMPTY;
            dat_q    <= 8'd0;
            q_byte_q <= 8'd0;
            stb_q    <= 1'b0;
        end else begin
            case (state_q)
                HOLD_EMPTY: begin
                    if (load_s) begin
                        state_q  <= HOLD_I;
                        dat_q    <= soft_byte(bus.i_ch_i, shamt_s);
                        q_byte_q <= soft_byte(bus.q_ch_i, shamt_s);
                        stb_q    <= 1'b1;
                    end else begin
                        state_q  <= HOLD_EMPTY;
                        stb_q    <= 1'b0;
                    end
                end
                HOLD_I: begin
                    if (bus.ack_i) begin
                        state_q <= HOLD_Q;
                        dat_q   <= q_byte_q;
                    end else begin
                        state_q <= HOLD_I;
                    end
                end
                HOLD_Q: begin
                    if (bus.ack_i) begin
                        state_q <= HOLD_EMPTY;
                        stb_q   <= 1'b0;
                    end else begin
                        state_q <= HOLD_Q;
                    end
                end
                default: begin
                    state_q <= HOLD_EMPTY;
                    stb_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack_o = ack_s;
    assign bus.stb_o = stb_q;
    assign bus.we_o  = stb_q;
    assign bus.cyc_o = cyc_o_q;
    assign bus.dat_o = dat_q;
endmodule

// File: tb/tb_ofdm_rx_80216.sv
// Bench for ofdm_rx_80216: directed scenarios plus randomized frames, scored against
// an arithmetic soft-bit model and a byte queue built from the accepted samples.
module tb_ofdm_rx_80216;
    localparam int SYM = 288;
    localparam int CP  = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ofdm_rx_80216_if bus();

    ofdm_rx_80216 #(.SYM_LEN(SYM), .CP_LEN(CP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    int         out_cnt = 0;
    int         ack_pct = 100;
    int         ack_low_left = 0;
    int         mdl_pos = 0;
    bit         mdl_new_frame = 1'b1;
    int         mdl_snr = 0;
    bit         gap = 1'b0;
    bit         prev_first = 1'b0;
    bit         prev_hold = 1'b0;
    logic [7:0] prev_dat = 8'd0;

    task automatic chk(input bit ok, input string tag, input longint obs, input longint exp);
        checks++;
        assert (ok) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Soft byte = floor(sample / 2^(8 - min(code, 8))), clamped to +/-127.
    function automatic logic [7:0] model_byte(input logic [15:0] raw, input int code);
        int x;
        int div;
        int v;
        x   = int'($signed(raw));
        div = 1 << (8 - ((code > 8) ? 8 : code));
        if (x >= 0) v = x / div;
        else        v = -((-x + div - 1) / div);
        if (v > 127)  v = 127;
        if (v < -127) v = -127;
        return v[7:0];
    endfunction

    function automatic int exp_count(input int n);
        int c = 0;
        for (int k = 0; k < n; k++) if ((k % SYM) >= CP) c += 2;
        return c;
    endfunction

    // Scoreboard and protocol monitor, sampling away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            gap = 1'b0; prev_first = 1'b0; prev_hold = 1'b0;
            mdl_pos = 0; mdl_new_frame = 1'b1;
        end else begin
            if (prev_hold) chk(bus.stb_o === 1'b1 && bus.dat_o === prev_dat, "stall_stable", bus.dat_o, prev_dat);
            if (bus.stb_o === 1'b1 && bus.ack_i === 1'b1) begin
                chk(bus.we_o === 1'b1, "we_eq_stb", bus.we_o, 1);
                chk(exp_q.size() != 0, "unexpected_byte", bus.dat_o, -1);
                if (exp_q.size() != 0) begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    chk(bus.dat_o === e, "byte", bus.dat_o, e);
                end
                out_cnt++;
            end
            prev_hold = (bus.stb_o === 1'b1) && (bus.ack_i === 1'b0);
            prev_dat  = bus.dat_o;

            if (prev_first) chk(bus.cyc_o === 1'b1, "cyc_o_rise", bus.cyc_o, 1);
            prev_first = 1'b0;

            if (gap && bus.cyc_o === 1'b1) chk(bus.ack_o === 1'b0, "ack_in_drain", bus.ack_o, 0);
            if (bus.cyc_o !== 1'b1) gap = 1'b0;
            else if (!bus.cyc_i)    gap = 1'b1;

            if (bus.cyc_i && bus.stb_i && bus.stb_o === 1'b1 && mdl_pos >= CP)
                chk(bus.ack_o === 1'b0, "ack_while_full", bus.ack_o, 0);

            if (!bus.cyc_i) begin
                mdl_pos = 0;
                mdl_new_frame = 1'b1;
            end else if (bus.stb_i && bus.ack_o === 1'b1) begin
                if (mdl_new_frame) begin
                    mdl_snr = int'(bus.snr);
                    mdl_new_frame = 1'b0;
                    prev_first = 1'b1;
                end
                if (mdl_pos >= CP) begin
                    exp_q.push_back(model_byte(bus.i_ch_i, mdl_snr));
                    exp_q.push_back(model_byte(bus.q_ch_i, mdl_snr));
                end
                mdl_pos = (mdl_pos + 1) % SYM;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (ack_low_left > 0) begin
            bus.ack_i = 1'b0;
            ack_low_left--;
        end else begin
            bus.ack_i = ($urandom_range(0, 99) < ack_pct);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk(bus.ack_o === 1'b0, {tag, "_ack_o"}, bus.ack_o, 0);
        chk(bus.stb_o === 1'b0, {tag, "_stb_o"}, bus.stb_o, 0);
        chk(bus.we_o  === 1'b0, {tag, "_we_o"},  bus.we_o,  0);
        chk(bus.cyc_o === 1'b0, {tag, "_cyc_o"}, bus.cyc_o, 0);
        chk(bus.dat_o === 8'd0, {tag, "_dat_o"}, bus.dat_o, 0);
    endtask

    task automatic send_frame(input int n, input int code, input bit fixed, input logic [15:0] iv,
                              input logic [15:0] qv, input int stb_pct, input int stall_at, input int rst_at);
        int cnt = 0;
        int guard = 0;
        bit stall_done = 1'b0;
        bus.cyc_i = 1'b1;
        bus.snr   = 4'(code);
        while (cnt < n && guard < 20000) begin
            if (rst_at >= 0 && cnt == rst_at) begin
                rst = 1'b1;
                bus.cyc_i = 1'b0;
                bus.stb_i = 1'b0;
                exp_q.delete();
                ack_low_left = 0;
                tick();
                check_zero_outputs("mid_rst");
                rst = 1'b0;
                out_cnt = 0;
                tick();
                return;
            end
            if (!stall_done && cnt == stall_at) begin
                ack_low_left = 10;
                stall_done = 1'b1;
            end
            bus.stb_i  = ($urandom_range(0, 99) < stb_pct);
            bus.i_ch_i = fixed ? iv : 16'($urandom);
            bus.q_ch_i = fixed ? qv : 16'($urandom);
            if (!fixed && cnt > 0) bus.snr = 4'($urandom);
            @(negedge clk);
            if (bus.cyc_i && bus.stb_i && bus.ack_o === 1'b1) cnt++;
            tick();
            guard++;
        end
        chk(guard < 20000, "input_timeout", cnt, n);
        bus.cyc_i = 1'b0;
        bus.stb_i = 1'b0;
        tick();
    endtask

    task automatic finish_frame(input int exp_bytes, input string tag);
        int g = 0;
        while (bus.cyc_o === 1'b1 && g < 3000) begin
            tick();
            g++;
        end
        chk(g < 3000, {tag, "_drain_timeout"}, g, 3000);
        chk(out_cnt == exp_bytes, {tag, "_bytes"}, out_cnt, exp_bytes);
        chk(exp_q.size() == 0, {tag, "_leftover"}, exp_q.size(), 0);
        out_cnt = 0;
    endtask

    initial begin
        rst = 1'b1;
        bus.i_ch_i = 16'd0; bus.q_ch_i = 16'd0;
        bus.cyc_i = 1'b0;   bus.stb_i = 1'b0;
        bus.snr = 4'd0;     bus.ack_i = 1'b1;
        repeat (3) tick();
        check_zero_outputs("reset");
        rst = 1'b0;
        tick();

        // Fixed pattern at maximum shift: +18 / -16 alternating.
        send_frame(288, 0, 1'b1, 16'h1234, 16'hF000, 100, -1, -1);
        finish_frame(512, "snr0");

        // Full-scale samples saturate to +/-127 at zero shift, and code 15 behaves like 8.
        send_frame(288, 8, 1'b1, 16'h7FFF, 16'h8000, 100, -1, -1);
        finish_frame(512, "snr8");
        send_frame(288, 15, 1'b1, 16'h7FFF, 16'h8000, 100, -1, -1);
        finish_frame(512, "snr15");

        // Downstream stall of 10 cycles mid-frame.
        send_frame(288, int'($urandom_range(0, 15)), 1'b0, 16'd0, 16'd0, 100, 150, -1);
        finish_frame(512, "stall");

        // Back-to-back frames: the second waits for cyc_o to fall.
        ack_pct = 70;
        send_frame(288, int'($urandom_range(0, 15)), 1'b0, 16'd0, 16'd0, 90, -1, -1);
        send_frame(288, int'($urandom_range(0, 15)), 1'b0, 16'd0, 16'd0, 90, -1, -1);
        finish_frame(1024, "b2b");
        ack_pct = 100;

        // Short frame: 8 samples past the prefix.
        send_frame(40, 5, 1'b0, 16'd0, 16'd0, 100, -1, -1);
        finish_frame(16, "short");

        // Reset mid-frame, then a clean full frame.
        send_frame(288, 3, 1'b0, 16'd0, 16'd0, 100, -1, 100);
        send_frame(288, 3, 1'b0, 16'd0, 16'd0, 100, -1, -1);
        finish_frame(512, "post_rst");

        // Randomized frames, including partial and multi-symbol lengths.
        for (int f = 0; f < 6; f++) begin
            int n;
            n = int'($urandom_range(1, 620));
            ack_pct = int'($urandom_range(30, 100));
            send_frame(n, int'($urandom_range(0, 15)), 1'b0, 16'd0, 16'd0,
                       int'($urandom_range(30, 100)), -1, -1);
            finish_frame(exp_count(n), "rand");
        end
        ack_pct = 100;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
